// File: rtl/fpio_fifo_nch.sv
`default_nettype none
// ============================================================================
// Module   : fpio_fifo_nch
// Summary  : Bank of independent circular FIFOs using fifo_in/fifo_out
//            handshakes, with per-channel flush and almost-full flags.
//            Define FPIO_FIFO_NCH_STATUS_EN to add sticky ovf/udf ports.
// Revision : 1.0
// ============================================================================
module fpio_fifo_nch #(
   parameter int NUM_CHANNELS = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int DEPTH        = 4,
   parameter int FIFO_BITS    = $clog2(DEPTH) + 1,
   parameter int AFULL_LEVEL  = DEPTH - 1
) (
   input  logic                               clock,
   input  logic                               reset,
   output logic [NUM_CHANNELS*FIFO_BITS-1:0]  in_avail,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_CHANNELS-1:0]            in_data_en,
   output logic [NUM_CHANNELS-1:0]            in_data_ack,
   output logic [NUM_CHANNELS*FIFO_BITS-1:0]  out_avail,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] out_data,
   input  logic [NUM_CHANNELS-1:0]            out_data_en,
   output logic [NUM_CHANNELS-1:0]            out_data_ack,
   input  logic [NUM_CHANNELS-1:0]            flush,
   output logic [NUM_CHANNELS-1:0]            afull
`ifdef FPIO_FIFO_NCH_STATUS_EN
   ,
   output logic [NUM_CHANNELS-1:0]            ovf,
   output logic [NUM_CHANNELS-1:0]            udf,
   input  logic [NUM_CHANNELS-1:0]            status_clr
`endif
);

   localparam int                   PTR_W   = $clog2(DEPTH);
   localparam logic [FIFO_BITS-1:0] C_DEPTH = FIFO_BITS'(DEPTH);
   localparam logic [FIFO_BITS-1:0] C_AFULL = FIFO_BITS'(AFULL_LEVEL);
   localparam logic [FIFO_BITS-1:0] C_ONE   = FIFO_BITS'(1);
   localparam logic [PTR_W-1:0]     C_PONE  = PTR_W'(1);

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
      logic [FIFO_BITS-1:0]  count_q, count_d;
      logic [FIFO_BITS-1:0]  in_avail_q;
      logic                  afull_q;
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      logic                  full, empty, wr_ack, rd_ack;

      // Acks are suppressed during reset and flush so no transfer is lost silently.
      always_comb begin
         full     = (count_q == C_DEPTH);
         empty    = (count_q == '0);
         wr_ack   = in_data_en[c]  & ~full  & ~flush[c] & ~reset;
         rd_ack   = out_data_en[c] & ~empty & ~flush[c] & ~reset;
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (flush[c]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
         end else begin
            if (wr_ack) wr_ptr_d = wr_ptr_q + C_PONE;
            if (rd_ack) rd_ptr_d = rd_ptr_q + C_PONE;
            if (wr_ack && !rd_ack)      count_d = count_q + C_ONE;
            else if (rd_ack && !wr_ack) count_d = count_q - C_ONE;
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_avail_q <= C_DEPTH;
            afull_q    <= 1'b0;
         end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_avail_q <= C_DEPTH - count_d;
            afull_q    <= (count_d >= C_AFULL);
         end
      end

      // Storage is cleared on reset so out_data reads zero until first write.
      always_ff @(posedge clock) begin
         if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         end else if (wr_ack) begin
            mem_q[wr_ptr_q] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      assign in_avail[c*FIFO_BITS +: FIFO_BITS]    = in_avail_q;
      assign out_avail[c*FIFO_BITS +: FIFO_BITS]   = count_q;
      assign out_data[c*DATA_WIDTH +: DATA_WIDTH]  = mem_q[rd_ptr_q];
      assign in_data_ack[c]                        = wr_ack;
      assign out_data_ack[c]                       = rd_ack;
      assign afull[c]                              = afull_q;

`ifdef FPIO_FIFO_NCH_STATUS_EN
      logic ovf_q, udf_q;

      always_ff @(posedge clock) begin
         if (reset || flush[c]) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
         end else begin
            if (in_data_en[c] && full)   ovf_q <= 1'b1;
            else if (status_clr[c])      ovf_q <= 1'b0;
            if (out_data_en[c] && empty) udf_q <= 1'b1;
            else if (status_clr[c])      udf_q <= 1'b0;
         end
      end

      assign ovf[c] = ovf_q;
      assign udf[c] = udf_q;
`endif
   end

endmodule
`default_nettype wire

// File: doc/fpio_fifo_nch.md
Name: fpio_fifo_nch

Overview:
- Multi-channel FIFO bank for the fpio datapath.
- Each of NUM_CHANNELS independent circular buffers uses the fifo_in handshake (avail/data/data_en/data_ack) on the write side and the fifo_out handshake on the read side.
- Adds over the single-channel interface:
  - parametrised depth and channel count;
  - per-channel flush;
  - per-channel almost-full threshold.
- Sits between fpio pin-sampling engines and their bus-side client.

Parameters:
- NUM_CHANNELS, 2, number of independent FIFOs (>=1).
- DATA_WIDTH, 8, bits per entry.
- DEPTH, 4, entries per channel; power of two, >=2.
- FIFO_BITS, $clog2(DEPTH)+1, width of every avail/count field; holds 0..DEPTH.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which afull asserts (1..DEPTH).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_avail  output  NUM_CHANNELS*FIFO_BITS  per-channel free slots (DEPTH-count).
- in_data  input  NUM_CHANNELS*DATA_WIDTH  per-channel write data.
- in_data_en  input  NUM_CHANNELS  per-channel write request.
- in_data_ack  output  NUM_CHANNELS  per-channel write accepted this cycle.
- out_avail  output  NUM_CHANNELS*FIFO_BITS  per-channel occupancy (count).
- out_data  output  NUM_CHANNELS*DATA_WIDTH  per-channel head entry.
- out_data_en  input  NUM_CHANNELS  per-channel read request.
- out_data_ack  output  NUM_CHANNELS  per-channel read accepted this cycle.
- flush  input  NUM_CHANNELS  per-channel synchronous flush.
- afull  output  NUM_CHANNELS  per-channel count >= AFULL_LEVEL.

Behaviour:
- Channel c uses slice [c*W +: W] of each flattened bus. Channels share no state.
- Per-channel state: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH), count (FIFO_BITS), storage DEPTH x DATA_WIDTH.
- Reset (sync, on any rising edge with reset=1): pointers=0, count=0. Result: in_avail=DEPTH, out_avail=0, in_data_ack=0, out_data_ack=0, afull=0. out_data=0 after reset; contents otherwise unspecified until written.
- Reset has priority over flush, write and read. Reset mid-transfer discards all data; no ack is produced in the reset cycle.
- Write accept (combinational): in_data_ack = in_data_en & (count!=DEPTH) & !flush.
  - On ack: storage[wr_ptr]<=in_data; wr_ptr<=wr_ptr+1.
- Read accept (combinational): out_data_ack = out_data_en & (count!=0) & !flush.
  - On ack: rd_ptr<=rd_ptr+1.
- out_data = storage[rd_ptr], valid whenever count!=0. Zero bypass: a word written in cycle N is visible at out_data and counted in out_avail from cycle N+1.
- Count update: +1 on write-only ack; -1 on read-only ack; unchanged when both ack in the same cycle.
- Full (count==DEPTH) with simultaneous write and read requests: write refused, read accepted, count becomes DEPTH-1.
- Empty (count==0) with simultaneous write and read requests: read refused, write accepted, count becomes 1.
- Flush (reset=0): pointers=0 and count=0 next cycle. Both acks are forced 0 in the flush cycle. Other channels are unaffected.
- Output timing: in_avail, out_avail and afull are registered from count; they update the cycle after the accepting edge. Acks are combinational from en/count/flush.
- Requests without ack are not queued. The client must hold en and data until ack, or may drop the request.
- Pointer wrap: DEPTH is a power of two, so natural overflow of log2(DEPTH)-bit pointers performs the wrap.

Optional Feature:
- Macro: FPIO_FIFO_NCH_STATUS_EN.
- When defined, three extra ports are added:
  - ovf (output NUM_CHANNELS): sticky; sets when in_data_en=1 while count==DEPTH and flush=0.
  - udf (output NUM_CHANNELS): sticky; sets when out_data_en=1 while count==0 and flush=0.
  - status_clr (input NUM_CHANNELS): clears that channel's ovf/udf next cycle. Set has priority over clear in the same cycle.
  - ovf/udf reset to 0; flush also clears them.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan (NUM_CHANNELS=2, DEPTH=4, DATA_WIDTH=8, AFULL_LEVEL=3):
- Reset then idle -> in_avail={4,4}, out_avail={0,0}, acks 0, afull=00.
- Ch0 writes 0x11,0x22,0x33,0x44 back-to-back, then a 5th write 0x55:
  - 4 acks; 5th in_data_ack=0; out_avail[0]=4; afull[0]=1 after 3rd write.
  - Channel 1 unchanged.
- Ch0 full, in_data_en and out_data_en both asserted:
  - read ack with out_data=0x11; write refused; out_avail[0]=3 next cycle.
- Empty ch1, write 0xA5 with out_data_en=1 in the same cycle:
  - write ack, no read ack.
  - Next cycle out_data[1]=0xA5, out_avail[1]=1; then read ack.
- Wrap: 10 interleaved write/read pairs of 0x00..0x09 on ch0 -> read data in order, count stays <=1, pointers wrap twice.
- Ch0 holding 2 entries, flush[0]=1 with in_data_en=1:
  - no ack; next cycle out_avail[0]=0, in_avail[0]=4.
  - Ch1 contents intact.
  - With FPIO_FIFO_NCH_STATUS_EN: prior ovf[0] cleared.
